// File: rtl/cnn_pkg.sv
// Shared CNN accelerator constants: phase codes and the default
// weight-bank geometry.
package cnn_pkg;

  typedef enum logic [4:0] {
    ST_INIT          = 5'd0,
    ST_CONV_WEIGHT_1 = 5'd1,
    ST_CONV_WEIGHT_2 = 5'd2,
    ST_CONV_WEIGHT_3 = 5'd3,
    ST_INPUT         = 5'd6,
    ST_CONV_LAYER1   = 5'd8,
    ST_CONV_LAYER2   = 5'd9,
    ST_CONV_LAYER3   = 5'd10
  } cnn_state_e;

  localparam int unsigned DEF_DATA_W   = 16;
  localparam int unsigned DEF_N_BANK1  = 6;
  localparam int unsigned DEF_N_BANK2  = 16;
  localparam int unsigned DEF_N_BANK3  = 32;
  localparam int unsigned DEF_W_DEPTH  = 3;
  localparam int unsigned DEF_IN_DEPTH = 18;

  function automatic logic is_load_state(input cnn_state_e s);
    return (s == ST_CONV_WEIGHT_1) || (s == ST_CONV_WEIGHT_2) ||
           (s == ST_CONV_WEIGHT_3) || (s == ST_INPUT);
  endfunction

endpackage

// File: rtl/cnn_load_sequencer_if.sv
// Valid/ready word stream feeding the load sequencer.
interface cnn_load_sequencer_if #(
  parameter int unsigned DATA_W = 16
) ();

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  modport master (output in_valid, output in_data, input  in_ready);
  modport slave  (input  in_valid, input  in_data, output in_ready);

endinterface

// File: rtl/cnn_load_sequencer_bank_addr_counter.sv
// Address-within-bank / bank-index counter pair used while loading
// weight banks and the input memory.
module bank_addr_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        inc,
  input  logic [15:0] depth,
  input  logic [7:0]  n_bank,
  output logic [15:0] addr,
  output logic [7:0]  bank,
  output logic        last
);

  logic addr_wrap;

  assign addr_wrap = (addr == depth - 16'd1);
  assign last      = addr_wrap && (bank == n_bank - 8'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
      bank <= '0;
    end else if (clr) begin
      addr <= '0;
      bank <= '0;
    end else if (inc) begin
      if (last) begin
        addr <= '0;
        bank <= '0;
      end else if (addr_wrap) begin
        addr <= '0;
        bank <= bank + 8'd1;
      end else begin
        addr <= addr + 16'd1;
      end
    end
  end

endmodule

// File: rtl/cnn_load_sequencer.sv
// Phase controller: streams weights and the input image into their
// memories, then steps through the three conv layers.
module cnn_load_sequencer
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned N_BANK1  = DEF_N_BANK1,
  parameter int unsigned N_BANK2  = DEF_N_BANK2,
  parameter int unsigned N_BANK3  = DEF_N_BANK3,
  parameter int unsigned W_DEPTH  = DEF_W_DEPTH,
  parameter int unsigned IN_DEPTH = DEF_IN_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  cnn_load_sequencer_if.slave  in_if,
  input  logic                 layer_done,
  output logic [4:0]           state,
  output logic [15:0]          mem_addr,
  output logic [DATA_W-1:0]    mem_din,
  output logic [N_BANK1-1:0]   w1_we,
  output logic [N_BANK2-1:0]   w2_we,
  output logic [N_BANK3-1:0]   w3_we,
  output logic                 i_we,
  output logic                 busy,
  output logic                 done
);

  cnn_state_e  state_q, state_d;
  logic        busy_q, done_q, done_d;
  logic        load, xfer, cnt_clr, last;
  logic [15:0] addr, depth;
  logic [7:0]  bank, n_bank;

  assign load           = is_load_state(state_q);
  // Abort wins over an in-flight word: it is neither accepted nor written.
  assign in_if.in_ready = load && !abort;
  assign xfer           = in_if.in_valid && in_if.in_ready;
  assign cnt_clr        = abort || !load || (xfer && last);

  assign state    = state_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign mem_din  = in_if.in_data;
  assign mem_addr = load ? addr : '0;

  always_comb begin
    depth  = 16'(W_DEPTH);
    n_bank = 8'd1;
    case (state_q)
      ST_CONV_WEIGHT_1: n_bank = 8'(N_BANK1);
      ST_CONV_WEIGHT_2: n_bank = 8'(N_BANK2);
      ST_CONV_WEIGHT_3: n_bank = 8'(N_BANK3);
      ST_INPUT:         depth  = 16'(IN_DEPTH);
      default: ;
    endcase
  end

  bank_addr_counter u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (cnt_clr),
    .inc    (xfer),
    .depth  (depth),
    .n_bank (n_bank),
    .addr   (addr),
    .bank   (bank),
    .last   (last)
  );

  always_comb begin
    w1_we = '0;
    w2_we = '0;
    w3_we = '0;
    i_we  = xfer && (state_q == ST_INPUT);
    for (int unsigned i = 0; i < N_BANK1; i++)
      w1_we[i] = xfer && (state_q == ST_CONV_WEIGHT_1) && (bank == 8'(i));
    for (int unsigned i = 0; i < N_BANK2; i++)
      w2_we[i] = xfer && (state_q == ST_CONV_WEIGHT_2) && (bank == 8'(i));
    for (int unsigned i = 0; i < N_BANK3; i++)
      w3_we[i] = xfer && (state_q == ST_CONV_WEIGHT_3) && (bank == 8'(i));
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    if (abort) begin
      state_d = ST_INIT;
    end else begin
      case (state_q)
        ST_INIT:          if (start)        state_d = ST_CONV_WEIGHT_1;
        ST_CONV_WEIGHT_1: if (xfer && last) state_d = ST_CONV_WEIGHT_2;
        ST_CONV_WEIGHT_2: if (xfer && last) state_d = ST_CONV_WEIGHT_3;
        ST_CONV_WEIGHT_3: if (xfer && last) state_d = ST_INPUT;
        ST_INPUT:         if (xfer && last) state_d = ST_CONV_LAYER1;
        ST_CONV_LAYER1:   if (layer_done)   state_d = ST_CONV_LAYER2;
        ST_CONV_LAYER2:   if (layer_done)   state_d = ST_CONV_LAYER3;
        ST_CONV_LAYER3: begin
          if (layer_done) begin
            state_d = ST_INIT;
            done_d  = 1'b1;
          end
        end
        default:                            state_d = ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != ST_INIT);
      done_q  <= done_d;
    end
  end

endmodule

// File: doc/cnn_load_sequencer.md
# cnn_load_sequencer

Top-level phase controller for the CNN accelerator. It owns the 5-bit `state` code that drives the accelerator, streams weights and the input image from a single 16-bit valid/ready source into the per-filter weight banks and the input memory, and holds each convolution phase until the datapath reports completion. It replaces the ad-hoc per-state write-enable and counter handling in the accelerator with one sequenced, handshaked block.

## Interface
Parameters:
- `DATA_W`, 16, stream/memory word width
- `N_BANK1`, 6, CONV1 weight banks
- `N_BANK2`, 16, CONV2 weight banks
- `N_BANK3`, 32, CONV3 weight banks
- `W_DEPTH`, 3, words per weight bank
- `IN_DEPTH`, 18, words in input memory

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock
- `rst_n`  in  1  async active-low reset
- `start`  in  1  begin a sequence; honoured only in INIT
- `abort`  in  1  synchronous return to INIT
- `in_valid`  in  1  stream word valid
- `in_data`  in  DATA_W  stream word
- `in_ready`  out  1  sequencer accepts a word
- `layer_done`  in  1  one-cycle pulse from the datapath: current conv layer finished
- `state`  out  5  phase code to the accelerator
- `mem_addr`  out  16  word address within the selected bank/memory
- `mem_din`  out  DATA_W  equals `in_data`
- `w1_we`  out  N_BANK1  one-hot CONV1 weight-bank write enable
- `w2_we`  out  N_BANK2  one-hot CONV2 weight-bank write enable
- `w3_we`  out  N_BANK3  one-hot CONV3 weight-bank write enable
- `i_we`  out  1  input-memory write enable
- `busy`  out  1  high in every state except INIT
- `done`  out  1  one-cycle pulse on CONV_LAYER3 completion

## Operation
- State codes: INIT=0, CONV_WEIGHT_1=1, CONV_WEIGHT_2=2, CONV_WEIGHT_3=3, INPUT=6, CONV_LAYER1=8, CONV_LAYER2=9, CONV_LAYER3=10. Other codes are never driven.
- Order: INIT -start-> W1 -> W2 -> W3 -> INPUT -> CL1 -> CL2 -> CL3 -> INIT (with `done`).
- Load states (W1/W2/W3/INPUT): `in_ready`=1. Transfer = `in_valid && in_ready`. During a transfer, exactly one write enable is high: bit `bank` of the current `wN_we`, or `i_we` in INPUT. Outside a transfer, all write enables are 0.
- The counters are `bank` (8 bits) and `addr` (16 bits), both 0 on entry to each load state. On each transfer, `addr` increments. When `addr`=depth-1, it wraps to 0 and `bank` increments. When the last bank and the last address are reached, the FSM advances and both counters clear.
- Depth is W_DEPTH for the weight states and IN_DEPTH for INPUT. INPUT has one bank.
- Word totals per sequence: 18 + 48 + 96 + 18 = 180 transfers.
- Conv states: `in_ready`=0 and all write enables are 0. The FSM waits for `layer_done`, then advances. `layer_done` is ignored in every other state.
- `abort` has priority over `start`, transfers, and `layer_done`. It returns the FSM to INIT, clears the counters, and drops every write enable in the same cycle. No `done` pulse is produced.
- `start` is ignored while `busy`.
- `mem_addr`=`addr` in load states and 0 otherwise. `mem_din`=`in_data` always.

## Timing
- Reset values: `state`=0, `busy`=0, `done`=0, `in_ready`=0, all write enables 0, `mem_addr`=0, counters 0.
- `state`, counters, `busy`, and `done` are registered. `in_ready`, the write enables, and `mem_addr` are combinational from the registered state and counters plus `in_valid`.
- The write occurs in the transfer cycle. The next state is visible one cycle after the last transfer, so there is no bubble cycle.
- `start` seen in INIT moves to W1 on the next edge. `in_ready` is high from that cycle.
- `layer_done` seen in CL3 produces `state`=0 and `done`=1 on the next edge. `done` drops one cycle later.
- `start` in the same cycle as the `done` edge is not accepted, because the FSM is not yet in INIT.
- A reset assertion mid-load returns all outputs to reset values immediately. Partially written banks are not cleared.

## Structure
- `cnn_pkg` holds the shared constants: the 5-bit state localparams and the default bank counts and depths. The accelerator and this block both import it.
- `bank_addr_counter` is a sub-module holding the `addr`/`bank` pair. Its inputs are `clr`, `inc`, `depth`, and `n_bank`; its outputs are `addr`, `bank`, and a combinational `last` flag. It is instantiated once.
- The FSM and the one-hot decode live in the top module.

## Test plan
- Reset then idle: outputs stay at reset values. `layer_done` pulses in INIT cause no state change.
- Full sequence with `in_valid` held at 1, data = index 0..179, and `layer_done` 5 cycles after each conv entry:
  - Exactly 180 write enables fire, with per-bank address pattern 0,1,2.
  - `w3_we[31]` fires at `mem_addr`=2 with data 161.
  - The final `i_we` fires at `mem_addr`=17 with data 179.
  - `state` sequence is 1,2,3,6,8,9,10,0, and `done` pulses once.
- Random `in_valid` gaps in W2: no write enable fires without `in_valid`, and the bank/address order is identical to the gap-free run.
- `abort` mid-W3 (bank 10, addr 1): the next cycle shows `state`=0, zero enables, and `busy`=0. A following `start` restarts at W1 bank 0 addr 0.
- `start` pulsed during CL2: no effect. `layer_done` held high in a load state: no advance.
- `rst_n` asserted asynchronously mid-INPUT: outputs are zero before the next clock edge.
